// File: rtl/vga_rect_fill.sv
// ---------------------------------------------------------------------------
// vga_rect_fill
//
// Purpose:
//   Turns one rectangle-fill command into a row-major stream of pixel writes,
//   one pixel per unstalled cycle. The FSM has three states: IDLE, FILL and
//   DONE. IDLE accepts a command. FILL emits the pixels. DONE pulses done for
//   one cycle and then returns to IDLE.
//
// Configuration:
//   VGA_FILL_CLIP_EN - when this macro is defined, the width and height are
//                      clipped to the visible screen when the command is
//                      accepted, so no off-screen pixel is ever emitted.
//                      When it is undefined, the command size is used as
//                      given and coordinates wrap by truncation.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   command strobe, sampled only while ready=1
//   cmd_x0      in   8   rectangle left column
//   cmd_y0      in   7   rectangle top row
//   cmd_w       in   8   width in pixels (0 allowed)
//   cmd_h       in   7   height in pixels (0 allowed)
//   cmd_colour  in   8   fill colour
//   pix_hold    in   1   downstream stall, freezes pixel generation
//   ready       out  1   high in IDLE
//   done        out  1   one-cycle pulse after the last pixel
//   pix_start   out  1   pixel-valid strobe
//   pix_data    out  32  {1'b0, y[6:0], x[7:0], 8'h00, colour}
// ---------------------------------------------------------------------------
module vga_rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd_x0,
  input  logic [6:0]  cmd_y0,
  input  logic [7:0]  cmd_w,
  input  logic [6:0]  cmd_h,
  input  logic [7:0]  cmd_colour,
  input  logic        pix_hold,
  output logic        ready,
  output logic        done,
  output logic        pix_start,
  output logic [31:0] pix_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Command latched at acceptance. The counters are 9 bits wide so that an
  // unclipped rectangle can run past column 255 or row 127 without the end
  // comparison aliasing.
  logic [8:0] r_x0;
  logic [8:0] r_x_last;
  logic [8:0] r_y_last;
  logic [8:0] r_x;
  logic [8:0] r_y;
  logic [7:0] r_colour;

  logic [8:0] w_eff_w;
  logic [8:0] w_eff_h;
  logic       w_zero;
  logic       w_accept;
  logic       w_x_end;
  logic       w_last_pix;
  logic       w_advance;

  // -------------------------------------------------------------------------
  // Effective size at acceptance
  // -------------------------------------------------------------------------
`ifdef VGA_FILL_CLIP_EN
  localparam logic [8:0] SCR_W = 9'(SCREEN_W);
  localparam logic [8:0] SCR_H = 9'(SCREEN_H);

  logic [8:0] w_room_x;
  logic [8:0] w_room_y;

  // These values are meaningful only when the origin is on screen. The
  // on-screen compare below guards against the wrapped result otherwise.
  assign w_room_x = SCR_W - {1'b0, cmd_x0};
  assign w_room_y = SCR_H - {2'b00, cmd_y0};

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_eff_w = 9'd0;
    w_eff_h = 9'd0;
    if ({1'b0, cmd_x0} < SCR_W)
      w_eff_w = ({1'b0, cmd_w} < w_room_x) ? {1'b0, cmd_w} : w_room_x;
    if ({2'b00, cmd_y0} < SCR_H)
      w_eff_h = ({2'b00, cmd_h} < w_room_y) ? {2'b00, cmd_h} : w_room_y;
  end
`else
  assign w_eff_w = {1'b0, cmd_w};
  assign w_eff_h = {2'b00, cmd_h};
`endif

  assign w_zero     = (w_eff_w == 9'd0) || (w_eff_h == 9'd0);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_x_end    = (r_x == r_x_last);
  assign w_last_pix = w_x_end && (r_y == r_y_last);
  assign w_advance  = (r_state == S_FILL) && !pix_hold;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments, so every
  // flop samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = w_zero ? S_DONE : S_FILL;
      S_FILL: if (!pix_hold && w_last_pix) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    pix_start = 1'b0;
    unique case (r_state)
      S_IDLE:  ready     = 1'b1;
      S_FILL:  pix_start = !pix_hold;
      S_DONE:  done      = 1'b1;
      default: ready     = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: command latch and scan counters
  // -------------------------------------------------------------------------
  // A zero-size command does not load the counters, so pix_data keeps showing
  // the last pixel that was actually emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0     <= '0;
      r_x_last <= '0;
      r_y_last <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else if (w_accept && !w_zero) begin
      r_x0     <= {1'b0, cmd_x0};
      r_x      <= {1'b0, cmd_x0};
      r_y      <= {2'b00, cmd_y0};
      r_x_last <= {1'b0, cmd_x0} + w_eff_w - 9'd1;
      r_y_last <= {2'b00, cmd_y0} + w_eff_h - 9'd1;
      r_colour <= cmd_colour;
    end else if (w_advance && !w_last_pix) begin
      if (w_x_end) begin
        r_x <= r_x0;
        r_y <= r_y + 9'd1;
      end else begin
        r_x <= r_x + 9'd1;
      end
    end
  end

  // pix_data comes only from registers: the current or pending pixel while
  // in FILL, and the last emitted pixel afterwards.
  assign pix_data = {1'b0, r_y[6:0], r_x[7:0], 8'h00, r_colour};

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 Parameter SCREEN_W, default 160, visible screen width in pixels.
REQ-002 Parameter SCREEN_H, default 120, visible screen height in pixels.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  command strobe, sampled only when ready=1.
REQ-006 cmd_x0  input  8  rectangle left column.
REQ-007 cmd_y0  input  7  rectangle top row.
REQ-008 cmd_w  input  8  width in pixels, 0 allowed.
REQ-009 cmd_h  input  7  height in pixels, 0 allowed.
REQ-010 cmd_colour  input  8  fill colour; downstream uses bits [2:0].
REQ-011 pix_hold  input  1  downstream stall; freezes pixel generation.
REQ-012 ready  output  1  high only in IDLE; command can be accepted.
REQ-013 done  output  1  one-cycle pulse after the last pixel of a command.
REQ-014 pix_start  output  1  pixel-valid strobe to the plot stage.
REQ-015 pix_data  output  32  [30:24]=y, [23:16]=x, [7:0]=colour; [31] and [15:8] always 0.

Function
REQ-016 States IDLE, FILL, DONE; one pixel per unstalled FILL cycle.
REQ-017 IDLE with start=1: latch x0, y0, effective w/h and colour; go to FILL, or to DONE if effective w or h is 0.
REQ-018 start while ready=0 is ignored, with no effect on the current command.
REQ-019 FILL: pix_start=1 and pix_data holds the current coordinate, registered (no combinational path from cmd_* to pix_data).
REQ-020 Scan order is row-major: x runs x0..x0+w-1, then x returns to x0 and y increments; first pixel (x0,y0) appears the cycle after acceptance.
REQ-021 pix_hold=1 in FILL: pix_start=0, counters and pix_data hold; resume at the same pixel when pix_hold=0.
REQ-022 After the pixel (x0+w-1, y0+h-1) is emitted, go to DONE; DONE asserts done=1 for one cycle, then IDLE (ready=1).
REQ-023 A w×h command emits exactly w*h pix_start pulses; latency from acceptance to done is w*h+1 cycles plus stall cycles.
REQ-024 Coordinate counters are 9 bits internally; emitted x is truncated to 8 bits and y to 7 bits.
REQ-025 pix_start=0 in IDLE and DONE; pix_data is don't-care-free and holds its last value.
REQ-026 cmd_* may change freely after acceptance without affecting the command in progress.

Reset
REQ-027 rst_n low forces IDLE immediately, including mid-FILL; the remaining pixels are discarded.
REQ-028 Reset values: ready=1 after release, done=0, pix_start=0, pix_data=0, counters=0.
REQ-029 No done pulse for a command aborted by reset.

Configuration
REQ-030 Macro VGA_FILL_CLIP_EN defined: at acceptance, effective w = min(w, SCREEN_W-x0), or 0 if x0>=SCREEN_W; effective h = min(h, SCREEN_H-y0), or 0 if y0>=SCREEN_H; no off-screen pixel is ever emitted.
REQ-031 Macro not defined: effective w/h equal cmd_w/cmd_h; off-screen coordinates are emitted truncated per REQ-024, and rejecting them is left to the downstream stage.

Verification
REQ-032 Reset, then x0=10,y0=5,w=3,h=2,colour=3 -> pixels (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); done 7 cycles after acceptance; ready=1 the following cycle.
REQ-033 w=0,h=5 -> no pix_start; done the cycle after acceptance.
REQ-034 4×1 fill with pix_hold high for 2 cycles after the 2nd pixel -> pix_start low and pix_data frozen for 2 cycles; 4 pixels total; done at cycle 7.
REQ-035 x0=158,y0=118,w=4,h=4 -> with VGA_FILL_CLIP_EN: 4 pixels (158..159 × 118..119); without it: 16 pixels, x wrapping 158,159,160,161.
REQ-036 rst_n asserted mid-fill of a 20×20 fill -> pix_start=0 immediately, no done, ready=1 after release; a new 1×1 command then produces exactly 1 pixel.
REQ-037 start held high continuously with 2×2 commands -> back-to-back commands, each accepted only in IDLE; every command yields 4 pixels and one done.
